// File: rtl/ray_generator.sv
// ray_generator: walks the camera pixel grid in raster order and streams one
// primary ray per pixel (origin = camera, direction = pixel - camera) over a
// valid/ready handshake. One start pulse produces one H_PIXELS x V_PIXELS frame.
// Optional feature macro: RAY_GEN_ABORT_EN adds an abort input that cancels a
// frame in LOAD or RUN without raising frame_done.
// Component index 0 is x, 1 is y, 2 is z for every vector port.
// pixel_x/pixel_y are $clog2 wide, widened to 1 bit when a dimension is 1.

module ray_generator #(
   parameter int H_PIXELS = 640,
   parameter int V_PIXELS = 480,
   localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1,
   localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2:0][11:0]    camera_location,
   input  logic [2:0][11:0]    beginnig_pixel_location,
   input  logic [2:0][11:0]    col_delta,
   input  logic [2:0][11:0]    row_delta,
`ifdef RAY_GEN_ABORT_EN
   input  logic                abort,
`endif
   output logic                ray_valid,
   input  logic                ray_ready,
   output logic [2:0][11:0]    ray_origin,
   output logic [2:0][12:0]    ray_direction,
   output logic [XW-1:0]       pixel_x,
   output logic [YW-1:0]       pixel_y,
   output logic                busy,
   output logic                frame_done
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);

   state_t             state_q, state_d;
   logic [2:0][11:0]   cam_q, cam_d;
   logic [2:0][11:0]   col_delta_q, col_delta_d;
   logic [2:0][11:0]   row_delta_q, row_delta_d;
   logic [2:0][11:0]   row_acc_q, row_acc_d;
   logic [2:0][11:0]   pix_acc_q, pix_acc_d;
   logic [2:0][12:0]   dir_q, dir_d;
   logic [XW-1:0]      px_q, px_d;
   logic [YW-1:0]      py_q, py_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [2:0][11:0]   col_step;
   logic [2:0][11:0]   row_step;
   logic               accept;

   // Direction is computed with a zero-extended 13-bit subtract so it can never overflow.
   function automatic logic [2:0][12:0] ray_dir(input logic [2:0][11:0] pix,
                                                input logic [2:0][11:0] cam);
      logic [2:0][12:0] res;
      for (int i = 0; i < 3; i++) begin
         res[i] = {1'b0, pix[i]} - {1'b0, cam[i]};
      end
      return res;
   endfunction

   // Per-component column and row steps; each component wraps modulo 4096 on its own.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         col_step[i] = pix_acc_q[i] + col_delta_q[i];
         row_step[i] = row_acc_q[i] + row_delta_q[i];
      end
   end

   assign accept = valid_q && ray_ready;

   // Next-state logic: latches constants in LOAD, then advances the raster walk on each accept.
   always_comb begin
      state_d     = state_q;
      cam_d       = cam_q;
      col_delta_d = col_delta_q;
      row_delta_d = row_delta_q;
      row_acc_d   = row_acc_q;
      pix_acc_d   = pix_acc_q;
      dir_d       = dir_q;
      px_d        = px_q;
      py_d        = py_q;
      valid_d     = valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               busy_d  = 1'b1;
            end
         end
         LOAD: begin
            cam_d       = camera_location;
            col_delta_d = col_delta;
            row_delta_d = row_delta;
            row_acc_d   = beginnig_pixel_location;
            pix_acc_d   = beginnig_pixel_location;
            dir_d       = ray_dir(beginnig_pixel_location, camera_location);
            px_d        = '0;
            py_d        = '0;
            valid_d     = 1'b1;
            state_d     = RUN;
         end
         RUN: begin
            if (accept) begin
               if (px_q < X_LAST) begin
                  px_d      = px_q + 1'b1;
                  pix_acc_d = col_step;
                  dir_d     = ray_dir(col_step, cam_q);
               end else if (py_q < Y_LAST) begin
                  px_d      = '0;
                  py_d      = py_q + 1'b1;
                  row_acc_d = row_step;
                  pix_acc_d = row_step;
                  dir_d     = ray_dir(row_step, cam_q);
               end else begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
`ifdef RAY_GEN_ABORT_EN
      if (abort && (state_q == LOAD || state_q == RUN)) begin
         state_d = IDLE;
         valid_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         px_d    = px_q;
         py_d    = py_q;
         dir_d   = dir_q;
      end
`endif
   end

   // State and registered-output flops; reset returns every output to zero immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cam_q       <= '0;
         col_delta_q <= '0;
         row_delta_q <= '0;
         row_acc_q   <= '0;
         pix_acc_q   <= '0;
         dir_q       <= '0;
         px_q        <= '0;
         py_q        <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cam_q       <= cam_d;
         col_delta_q <= col_delta_d;
         row_delta_q <= row_delta_d;
         row_acc_q   <= row_acc_d;
         pix_acc_q   <= pix_acc_d;
         dir_q       <= dir_d;
         px_q        <= px_d;
         py_q        <= py_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ray_valid     = valid_q;
   assign ray_origin    = cam_q;
   assign ray_direction = dir_q;
   assign pixel_x       = px_q;
   assign pixel_y       = py_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;

endmodule

// File: tb/tb_ray_generator.sv
// tb_ray_generator: directed, table-driven bench for ray_generator with a
// 4x3 frame. Optional feature macro: RAY_GEN_ABORT_EN enables the abort sequence.

module tb_ray_generator;

   localparam int H = 4;
   localparam int V = 3;
   localparam int NRAYS = H * V;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                ray_ready = 1'b0;
   logic [2:0][11:0]    camera_location = '0;
   logic [2:0][11:0]    beginnig_pixel_location = '0;
   logic [2:0][11:0]    col_delta = '0;
   logic [2:0][11:0]    row_delta = '0;
`ifdef RAY_GEN_ABORT_EN
   logic                abort = 1'b0;
`endif
   logic                ray_valid;
   logic [2:0][11:0]    ray_origin;
   logic [2:0][12:0]    ray_direction;
   logic [1:0]          pixel_x;
   logic [1:0]          pixel_y;
   logic                busy;
   logic                frame_done;

   typedef struct {
      int px;
      int py;
      int dx;
      int dy;
      int dz;
   } ray_vec_t;

   ray_vec_t tbl [NRAYS];
   int checks = 0;
   int errors = 0;

   ray_generator #(.H_PIXELS(H), .V_PIXELS(V)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .start                   (start),
      .camera_location         (camera_location),
      .beginnig_pixel_location (beginnig_pixel_location),
      .col_delta               (col_delta),
      .row_delta               (row_delta),
`ifdef RAY_GEN_ABORT_EN
      .abort                   (abort),
`endif
      .ray_valid               (ray_valid),
      .ray_ready               (ray_ready),
      .ray_origin              (ray_origin),
      .ray_direction           (ray_direction),
      .pixel_x                 (pixel_x),
      .pixel_y                 (pixel_y),
      .busy                    (busy),
      .frame_done              (frame_done)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Hard stop in case something upstream wedges the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0][11:0] cam, input logic [2:0][11:0] beg,
                                input logic [2:0][11:0] col, input logic [2:0][11:0] row);
      camera_location         = cam;
      beginnig_pixel_location = beg;
      col_delta               = col;
      row_delta               = row;
   endtask

   task automatic applyStandard();
      applyStimulus({12'd1002, 12'd2000, 12'd4090}, {12'd798, 12'd1541, 12'd2785},
                    {12'd0, 12'd0, 12'd36}, {12'd82, 12'd89, 12'd0});
   endtask

   task automatic checkRay(input string tag, input int k);
      checkOutput({tag, "_px"}, int'(pixel_x), tbl[k].px);
      checkOutput({tag, "_py"}, int'(pixel_y), tbl[k].py);
      checkOutput({tag, "_dx"}, int'($signed(ray_direction[0])), tbl[k].dx);
      checkOutput({tag, "_dy"}, int'($signed(ray_direction[1])), tbl[k].dy);
      checkOutput({tag, "_dz"}, int'($signed(ray_direction[2])), tbl[k].dz);
      checkOutput({tag, "_ox"}, int'(ray_origin[0]), 4090);
      checkOutput({tag, "_oz"}, int'(ray_origin[2]), 1002);
   endtask

   // Pulse start, check the LOAD cycle, and land on the first valid ray
   task automatic startFrame(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput({tag, "_load_busy"}, int'(busy), 1);
      checkOutput({tag, "_load_valid"}, int'(ray_valid), 0);
      tick();
      checkOutput({tag, "_first_valid"}, int'(ray_valid), 1);
   endtask

   // Consume a whole standard frame against the table with a ready pattern
   task automatic streamFrame(input string tag, input logic [31:0] pattern, input bit disturb);
      int idx = 0;
      int cyc = 0;
      while (idx < NRAYS && cyc < 200) begin
         checkOutput({tag, "_valid"}, int'(ray_valid), 1);
         checkRay(tag, idx);
         ray_ready = pattern[cyc % 32];
         start = (disturb && cyc == 4) ? 1'b1 : 1'b0;
         if (disturb && cyc == 2)
            applyStimulus({12'd7, 12'd7, 12'd7}, {12'd100, 12'd200, 12'd300},
                          {12'd5, 12'd5, 12'd5}, {12'd9, 12'd9, 12'd9});
         if (ray_ready) idx++;
         cyc++;
         tick();
      end
      start = 1'b0;
      checkOutput({tag, "_ray_count"}, idx, NRAYS);
      checkOutput({tag, "_done_pulse"}, int'(frame_done), 1);
      checkOutput({tag, "_done_busy"}, int'(busy), 1);
      checkOutput({tag, "_done_valid"}, int'(ray_valid), 0);
      tick();
      checkOutput({tag, "_done_clear"}, int'(frame_done), 0);
      checkOutput({tag, "_idle_busy"}, int'(busy), 0);
      tick();
      checkOutput({tag, "_no_restart"}, int'(ray_valid), 0);
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      checkOutput({tag, "_idle_reached"}, int'(busy), 0);
   endtask

   initial begin
      // Expected rays of the standard 4x3 frame, raster order
      tbl[0]  = '{0, 0, -1305, -459, -204};
      tbl[1]  = '{1, 0, -1269, -459, -204};
      tbl[2]  = '{2, 0, -1233, -459, -204};
      tbl[3]  = '{3, 0, -1197, -459, -204};
      tbl[4]  = '{0, 1, -1305, -370, -122};
      tbl[5]  = '{1, 1, -1269, -370, -122};
      tbl[6]  = '{2, 1, -1233, -370, -122};
      tbl[7]  = '{3, 1, -1197, -370, -122};
      tbl[8]  = '{0, 2, -1305, -281, -40};
      tbl[9]  = '{1, 2, -1269, -281, -40};
      tbl[10] = '{2, 2, -1233, -281, -40};
      tbl[11] = '{3, 2, -1197, -281, -40};

      // Reset values
      #12;
      checkOutput("rst_valid", int'(ray_valid), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(frame_done), 0);
      checkOutput("rst_origin", int'(ray_origin[0]), 0);
      checkOutput("rst_dir", int'(ray_direction[0]), 0);
      checkOutput("rst_px", int'(pixel_x), 0);
      checkOutput("rst_py", int'(pixel_y), 0);
      tick();
      rst = 1'b0;
      tick();

      // Full-rate frame
      $display("[TB] full-rate frame");
      applyStandard();
      ray_ready = 1'b1;
      startFrame("full");
      streamFrame("full", 32'hFFFF_FFFF, 1'b0);

      // Stalled frame, constants disturbed after LOAD and a stray start mid-run
      $display("[TB] stalled frame");
      applyStandard();
      startFrame("stall");
      streamFrame("stall", 32'b1001_1001_1001_0101_0011_1001_1100_1001, 1'b1);

      // Per-component wrap modulo 4096
      $display("[TB] wrap frame");
      applyStimulus({12'd0, 12'd0, 12'd0}, {12'd0, 12'd0, 12'd4090},
                    {12'd0, 12'd0, 12'd10}, {12'd0, 12'd1, 12'd0});
      ray_ready = 1'b1;
      startFrame("wrap");
      checkOutput("wrap_dx0", int'($signed(ray_direction[0])), 4090);
      tick();
      checkOutput("wrap_px1", int'(pixel_x), 1);
      checkOutput("wrap_dx1", int'($signed(ray_direction[0])), 4);
      tick();
      checkOutput("wrap_dx2", int'($signed(ray_direction[0])), 14);
      waitIdle("wrap");

      // Reset in the middle of a frame
      $display("[TB] mid-frame reset");
      applyStandard();
      ray_ready = 1'b1;
      startFrame("rstmid");
      for (int i = 0; i < 5; i++) tick();
      checkRay("rstmid_r5", 5);
      rst = 1'b1;
      #1;
      checkOutput("rstmid_valid", int'(ray_valid), 0);
      checkOutput("rstmid_busy", int'(busy), 0);
      checkOutput("rstmid_done", int'(frame_done), 0);
      checkOutput("rstmid_px", int'(pixel_x), 0);
      checkOutput("rstmid_py", int'(pixel_y), 0);
      checkOutput("rstmid_dir", int'(ray_direction[0]), 0);
      checkOutput("rstmid_origin", int'(ray_origin[0]), 0);
      tick();
      rst = 1'b0;
      tick();
      checkOutput("rstmid_after_done", int'(frame_done), 0);
      checkOutput("rstmid_after_busy", int'(busy), 0);
      startFrame("restart");
      streamFrame("restart", 32'hFFFF_FFFF, 1'b0);

`ifdef RAY_GEN_ABORT_EN
      // Abort while ray 3 is presented, accept in the same cycle discarded
      $display("[TB] abort");
      applyStandard();
      ray_ready = 1'b1;
      startFrame("abort");
      for (int i = 0; i < 3; i++) tick();
      checkRay("abort_r3", 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_valid", int'(ray_valid), 0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(frame_done), 0);
      tick();
      checkOutput("abort_done_later", int'(frame_done), 0);
      checkOutput("abort_stay_idle", int'(ray_valid), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
